seven_segment_capture: RTL and testbench

//  Receive end of the PMOD 7-segment link: samples the 7 segment lines and the

---
 rtl/seven_segment_capture_pkg.sv | 48 ++++
 rtl/seven_segment_pattern_decode.sv | 38 +++
 rtl/seven_segment_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_capture_pkg.sv
// seven_segment_capture_pkg
//   Shared definitions for the 7-segment receive path.
//   - Segment bit indices (bit0 = A .. bit6 = G, 1 = lit).
//   - The 16 hex digit patterns. The byte-to-7-segment encoder imports the same
//     constants, so the encode and decode tables stay identical.
//   - Capture FSM state type and the decoder result struct.
package seven_segment_capture_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Patterns written as GFEDCBA.
  localparam logic [SEG_W-1:0] PAT_0 = 7'h3F;
  localparam logic [SEG_W-1:0] PAT_1 = 7'h06;
  localparam logic [SEG_W-1:0] PAT_2 = 7'h5B;
  localparam logic [SEG_W-1:0] PAT_3 = 7'h4F;
  localparam logic [SEG_W-1:0] PAT_4 = 7'h66;
  localparam logic [SEG_W-1:0] PAT_5 = 7'h6D;
  localparam logic [SEG_W-1:0] PAT_6 = 7'h7D;
  localparam logic [SEG_W-1:0] PAT_7 = 7'h07;
  localparam logic [SEG_W-1:0] PAT_8 = 7'h7F;
  localparam logic [SEG_W-1:0] PAT_9 = 7'h6F;
  localparam logic [SEG_W-1:0] PAT_A = 7'h77;
  localparam logic [SEG_W-1:0] PAT_B = 7'h7C;
  localparam logic [SEG_W-1:0] PAT_C = 7'h39;
  localparam logic [SEG_W-1:0] PAT_D = 7'h5E;
  localparam logic [SEG_W-1:0] PAT_E = 7'h79;
  localparam logic [SEG_W-1:0] PAT_F = 7'h71;

  typedef enum logic [1:0] {
    ST_ALIGN  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } decode_t;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// seven_segment_pattern_decode
//   Combinational lookup from a 7-segment pattern to {valid, nibble}.
//   Anything that is not one of the 16 hex patterns (including all-dark)
//   reports valid = 0 and nibble = 0.
// Ports
//   i_segments  in   7  segment pattern, bit0 = A .. bit6 = G
//   o_result    out  5  {valid, nibble}
module seven_segment_pattern_decode
  import seven_segment_capture_pkg::*;
(
  input  logic [SEG_W-1:0] i_segments,
  output decode_t          o_result
);

  always_comb begin
    o_result = '0;
    case (i_segments)
      PAT_0: o_result = '{valid: 1'b1, nibble: 4'h0};
      PAT_1: o_result = '{valid: 1'b1, nibble: 4'h1};
      PAT_2: o_result = '{valid: 1'b1, nibble: 4'h2};
      PAT_3: o_result = '{valid: 1'b1, nibble: 4'h3};
      PAT_4: o_result = '{valid: 1'b1, nibble: 4'h4};
      PAT_5: o_result = '{valid: 1'b1, nibble: 4'h5};
      PAT_6: o_result = '{valid: 1'b1, nibble: 4'h6};
      PAT_7: o_result = '{valid: 1'b1, nibble: 4'h7};
      PAT_8: o_result = '{valid: 1'b1, nibble: 4'h8};
      PAT_9: o_result = '{valid: 1'b1, nibble: 4'h9};
      PAT_A: o_result = '{valid: 1'b1, nibble: 4'hA};
      PAT_B: o_result = '{valid: 1'b1, nibble: 4'hB};
      PAT_C: o_result = '{valid: 1'b1, nibble: 4'hC};
      PAT_D: o_result = '{valid: 1'b1, nibble: 4'hD};
      PAT_E: o_result = '{valid: 1'b1, nibble: 4'hE};
      PAT_F: o_result = '{valid: 1'b1, nibble: 4'hF};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// seven_segment_capture
//   Receive end of the PMOD 7-segment link. Synchronises the segment and
//   digit-select lines, waits for each multiplexed digit to settle, decodes it
//   and reassembles the displayed byte {hi, lo}.
// Parameters
//   SETTLE_CYCLES  cycles segments/digit must be stable before a sample (>= 2)
//   SYNC_STAGES    synchroniser depth on every input (>= 2)
// Ports
//   i_clk       in   1  system clock
//   i_rst       in   1  asynchronous active-high reset (released synchronously)
//   i_segments  in   7  async segment lines, bit0 = A .. bit6 = G, 1 = lit
//   i_digit     in   1  async digit select, 0 = low nibble, 1 = high nibble
//   o_data      out  8  last reassembled byte
//   o_valid     out  1  one-cycle pulse, o_data updated
//   o_error     out  1  one-cycle pulse, settled pattern not a hex digit
// Build option
//   SEVEN_SEGMENT_CAPTURE_CHANGE_FILTER_EN: when defined, a byte equal to the
//   previously emitted one does not pulse o_valid (the first byte after reset
//   always does).
module seven_segment_capture
  import seven_segment_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SEG_W-1:0] i_segments,
  input  logic             i_digit,
  output logic [7:0]       o_data,
  output logic             o_valid,
  output logic             o_error
);

  // After reset the synchroniser still holds zeros, so the first real input
  // level would look like an edge. ALIGN waits this many cycles before it
  // trusts an edge on the digit line.
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_MAX    = (SETTLE_CYCLES > ARM_CYCLES) ? SETTLE_CYCLES : ARM_CYCLES + 1;
  localparam int CNT_W      = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_CYCLES);

  // Reset is asserted asynchronously but released on a clock edge.
  logic [1:0] rst_pipe_q, rst_pipe_d;
  logic       rst_int;

  always_comb begin
    rst_pipe_d = {rst_pipe_q[0], 1'b0};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rst_pipe_q <= 2'b11;
    end else begin
      rst_pipe_q <= rst_pipe_d;
    end
  end

  assign rst_int = rst_pipe_q[1];

  // Synchroniser chain, {digit, segments} travel together.
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = {i_digit, i_segments};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  logic [SEG_W-1:0] seg_s;
  logic             dig_s;

  assign seg_s = sync_q[SYNC_STAGES-1][SEG_W-1:0];
  assign dig_s = sync_q[SYNC_STAGES-1][7];

  decode_t dec;

  seven_segment_pattern_decode u_decode (
    .i_segments (seg_s),
    .o_result   (dec)
  );

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEG_W-1:0] seg_prev_q, seg_prev_d;
  logic             dig_prev_q, dig_prev_d;
  logic [3:0]       lo_nib_q, lo_nib_d;
  logic             lo_flag_q, lo_flag_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
`ifdef SEVEN_SEGMENT_CAPTURE_CHANGE_FILTER_EN
  logic             emitted_q, emitted_d;
`endif

  logic       seg_change;
  logic       dig_edge;
  logic       take_sample;
  logic [7:0] new_byte;

  // Next-state logic: phase tracking, settle counting, sampling and byte
  // assembly. The high nibble is never stored; a valid high sample either
  // completes a byte with the held low nibble or is dropped.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seg_prev_d  = seg_s;
    dig_prev_d  = dig_s;
    lo_nib_d    = lo_nib_q;
    lo_flag_d   = lo_flag_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_CHANGE_FILTER_EN
    emitted_d   = emitted_q;
`endif
    take_sample = 1'b0;
    new_byte    = {dec.nibble, lo_nib_q};

    seg_change = (seg_s != seg_prev_q);
    dig_edge   = (dig_s != dig_prev_q);

    case (state_q)
      ST_ALIGN: begin
        if (cnt_q != ARM_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (dig_edge) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (dig_edge) begin
          // The phase that just ended was too short to sample.
          cnt_d = '0;
          if (!dig_prev_q) begin
            lo_flag_d = 1'b0;
          end
        end else if (seg_change) begin
          cnt_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d     = ST_HELD;
          take_sample = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (dig_edge || seg_change) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ALIGN;
        cnt_d   = '0;
      end
    endcase

    if (take_sample) begin
      if (!dec.valid) begin
        error_d = 1'b1;
        if (!dig_s) begin
          lo_flag_d = 1'b0;
        end
      end else if (!dig_s) begin
        lo_nib_d  = dec.nibble;
        lo_flag_d = 1'b1;
      end else if (lo_flag_q) begin
        lo_flag_d = 1'b0;
        data_d    = new_byte;
`ifdef SEVEN_SEGMENT_CAPTURE_CHANGE_FILTER_EN
        valid_d   = !emitted_q || (new_byte != data_q);
        emitted_d = 1'b1;
`else
        valid_d   = 1'b1;
`endif
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge rst_int) begin
    if (rst_int) begin
      state_q    <= ST_ALIGN;
      cnt_q      <= '0;
      seg_prev_q <= '0;
      dig_prev_q <= 1'b0;
      lo_nib_q   <= '0;
      lo_flag_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_CHANGE_FILTER_EN
      emitted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seg_prev_q <= seg_prev_d;
      dig_prev_q <= dig_prev_d;
      lo_nib_q   <= lo_nib_d;
      lo_flag_q  <= lo_flag_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
`ifdef SEVEN_SEGMENT_CAPTURE_CHANGE_FILTER_EN
      emitted_q  <= emitted_d;
`endif
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_error = error_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture
//   Directed bench for seven_segment_capture: drives digit phases by hand and
//   compares pulse counts, bytes and latencies against hand-computed values.
module tb_seven_segment_capture;

  logic       clk;
  logic       rst;
  logic [6:0] segments;
  logic       digit;
  logic [7:0] data;
  logic       valid;
  logic       error;

  int checks;
  int errors;
  int valid_cnt;
  int err_cnt;
  int both_cnt;
  logic [7:0] last_data;

  seven_segment_capture #(
    .SETTLE_CYCLES (16),
    .SYNC_STAGES   (2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_segments (segments),
    .i_digit    (digit),
    .o_data     (data),
    .o_valid    (valid),
    .o_error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      last_data = data;
    end
    if (error === 1'b1) err_cnt++;
    if (valid === 1'b1 && error === 1'b1) both_cnt++;
  end

  task automatic clear_counts();
    valid_cnt = 0;
    err_cnt   = 0;
    last_data = 8'h00;
  endtask

  task automatic do_reset(input logic init_digit);
    rst      = 1'b1;
    digit    = init_digit;
    segments = 7'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1 clear_counts();
  endtask

  // Hold one digit phase for n cycles; lat = first cycle o_valid seen (0 = none).
  task automatic phase(input logic dig, input logic [6:0] seg, input int n, output int lat);
    digit    = dig;
    segments = seg;
    lat      = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 && lat == 0) lat = i;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    digit    = 1'b1;
    segments = 7'h00;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b want 0", error); end
    do_reset(1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL idle_data got %h want 00", data); end
    checks++; if (valid_cnt !== 0) begin errors++; $display("[TB] FAIL idle_valid got %0d want 0", valid_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("[TB] FAIL idle_error got %0d want 0", err_cnt); end
  endtask

  task automatic test_basic_pair();
    int lat;
    do_reset(1'b1);
    phase(1'b0, 7'h7C, 40, lat);
    checks++; if (valid_cnt !== 0) begin errors++; $display("[TB] FAIL lo_alone_valid got %0d want 0", valid_cnt); end
    phase(1'b1, 7'h4F, 40, lat);
    checks++; if (lat !== 19) begin errors++; $display("[TB] FAIL basic_latency got %0d want 19", lat); end
    checks++; if (data !== 8'h3B) begin errors++; $display("[TB] FAIL basic_data got %h want 3b", data); end
    checks++; if (valid_cnt !== 1) begin errors++; $display("[TB] FAIL basic_valid_count got %0d want 1", valid_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("[TB] FAIL basic_error_count got %0d want 0", err_cnt); end
  endtask

  task automatic test_invalid_lo();
    int lat;
    do_reset(1'b1);
    phase(1'b0, 7'h06, 40, lat);
    phase(1'b1, 7'h06, 40, lat);
    checks++; if (last_data !== 8'h11 || valid_cnt !== 1) begin errors++; $display("[TB] FAIL inv_first_byte got %h/%0d want 11/1", last_data, valid_cnt); end
    phase(1'b0, 7'h00, 40, lat);
    checks++; if (err_cnt !== 1) begin errors++; $display("[TB] FAIL inv_error_count got %0d want 1", err_cnt); end
    phase(1'b1, 7'h3F, 40, lat);
    checks++; if (valid_cnt !== 1) begin errors++; $display("[TB] FAIL inv_hi_valid got %0d want 1", valid_cnt); end
    checks++; if (data !== 8'h11) begin errors++; $display("[TB] FAIL inv_data_kept got %h want 11", data); end
  endtask

  task automatic test_short_lo();
    int lat;
    do_reset(1'b1);
    phase(1'b0, 7'h5B, 40, lat);
    phase(1'b1, 7'h3F, 10, lat);
    phase(1'b0, 7'h06, 10, lat);
    phase(1'b1, 7'h3F, 40, lat);
    checks++; if (valid_cnt !== 0) begin errors++; $display("[TB] FAIL short_valid got %0d want 0", valid_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("[TB] FAIL short_error got %0d want 0", err_cnt); end
  endtask

  task automatic test_hi_first();
    int lat;
    do_reset(1'b0);
    phase(1'b1, 7'h77, 40, lat);
    checks++; if (valid_cnt !== 0) begin errors++; $display("[TB] FAIL hifirst_valid got %0d want 0", valid_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("[TB] FAIL hifirst_error got %0d want 0", err_cnt); end
    phase(1'b0, 7'h6D, 40, lat);
    phase(1'b1, 7'h77, 40, lat);
    checks++; if (valid_cnt !== 1) begin errors++; $display("[TB] FAIL hifirst_pair_valid got %0d want 1", valid_cnt); end
    checks++; if (data !== 8'hA5) begin errors++; $display("[TB] FAIL hifirst_data got %h want a5", data); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int want;
    do_reset(1'b1);
    for (int p = 0; p < 3; p++) begin
      phase(1'b0, 7'h6D, 30, lat);
      phase(1'b1, 7'h77, 30, lat);
    end
    phase(1'b0, 7'h66, 30, lat);
    phase(1'b1, 7'h77, 30, lat);
`ifdef SEVEN_SEGMENT_CAPTURE_CHANGE_FILTER_EN
    want = 2;
`else
    want = 4;
`endif
    checks++; if (valid_cnt !== want) begin errors++; $display("[TB] FAIL b2b_valid_count got %0d want %0d", valid_cnt, want); end
    checks++; if (last_data !== 8'hA4) begin errors++; $display("[TB] FAIL b2b_last_data got %h want a4", last_data); end
  endtask

  task automatic test_glitch();
    int lat;
    do_reset(1'b1);
    phase(1'b0, 7'h79, 40, lat);
    phase(1'b1, 7'h71, 8, lat);
    phase(1'b1, 7'h70, 1, lat);
    phase(1'b1, 7'h71, 40, lat);
    checks++; if (lat !== 19) begin errors++; $display("[TB] FAIL glitch_latency got %0d want 19", lat); end
    checks++; if (data !== 8'hFE) begin errors++; $display("[TB] FAIL glitch_data got %h want fe", data); end
    checks++; if (valid_cnt !== 1 || err_cnt !== 0) begin errors++; $display("[TB] FAIL glitch_counts got v%0d e%0d want v1 e0", valid_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset(1'b1);
    phase(1'b0, 7'h06, 40, lat);
    phase(1'b1, 7'h06, 40, lat);
    checks++; if (data !== 8'h11) begin errors++; $display("[TB] FAIL mid_pre_data got %h want 11", data); end
    phase(1'b0, 7'h5B, 40, lat);
    phase(1'b1, 7'h3F, 8, lat);
    rst = 1'b1;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_data got %h want 00", data); end
    checks++; if (valid !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_pulses got v%b e%b want v0 e0", valid, error); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_counts();
    phase(1'b1, 7'h3F, 40, lat);
    phase(1'b0, 7'h6D, 40, lat);
    checks++; if (valid_cnt !== 0) begin errors++; $display("[TB] FAIL mid_stale_valid got %0d want 0", valid_cnt); end
    phase(1'b1, 7'h77, 40, lat);
    checks++; if (valid_cnt !== 1) begin errors++; $display("[TB] FAIL mid_after_valid got %0d want 1", valid_cnt); end
    checks++; if (data !== 8'hA5) begin errors++; $display("[TB] FAIL mid_after_data got %h want a5", data); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    both_cnt  = 0;
    valid_cnt = 0;
    err_cnt   = 0;
    last_data = 8'h00;
    rst       = 1'b1;
    digit     = 1'b1;
    segments  = 7'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_pair();
    test_invalid_lo();
    test_short_lo();
    test_hi_first();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    checks++; if (both_cnt !== 0) begin errors++; $display("[TB] FAIL valid_and_error_together got %0d want 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
